// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IF/MEM memory-port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_BUSY = 3'd1,
    D_RESP = 3'd2,
    I_BUSY = 3'd3,
    I_RESP = 3'd4
  } arb_state_e;

endpackage

// File: rtl/mem_arb_perf_cnt.sv
// Saturating cycle counter; counts clocks while en is high and sticks at all-ones.
module mem_arb_perf_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between IF fetches and MEM loads/stores (data first).
// Optional stall counters enabled by defining MEM_PORT_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_adr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_adr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait
`endif
);

  arb_state_e        state, state_nxt;
  logic              mem_req_nxt, mem_we_nxt, if_ready_nxt, dm_ready_nxt;
  logic [ADDR_W-1:0] mem_adr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, if_rdata_nxt, dm_rdata_nxt;
  logic              dm_any;

  // A simultaneous read+write from MEM is treated as a store.
  assign dm_any = dm_read | dm_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_adr   <= mem_adr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_rdata  <= dm_rdata_nxt;
      if_ready  <= if_ready_nxt;
      dm_ready  <= dm_ready_nxt;
    end
  end

  // Ready pulses are registered on entry to the RESP state, so they last exactly one cycle.
  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_adr_nxt   = mem_adr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_ready_nxt  = 1'b0;
    dm_ready_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (dm_any) begin
          mem_adr_nxt   = dm_adr;
          mem_wdata_nxt = dm_wdata;
          mem_we_nxt    = dm_write;
          mem_req_nxt   = 1'b1;
          state_nxt     = D_BUSY;
        end else if (if_req) begin
          mem_adr_nxt = if_adr;
          mem_we_nxt  = 1'b0;
          mem_req_nxt = 1'b1;
          state_nxt   = I_BUSY;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          mem_req_nxt  = 1'b0;
          dm_ready_nxt = 1'b1;
          state_nxt    = D_RESP;
          if (!mem_we) begin
            dm_rdata_nxt = mem_rdata;
          end
        end
      end
      I_BUSY: begin
        if (mem_ack) begin
          mem_req_nxt  = 1'b0;
          if_ready_nxt = 1'b1;
          if_rdata_nxt = mem_rdata;
          state_nxt    = I_RESP;
        end
      end
      D_RESP, I_RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign stall_mem = dm_any & ~dm_ready;
  assign stall_if  = stall_mem | (if_req & ~if_ready);

`ifdef MEM_PORT_ARB_PERF_EN
  mem_arb_perf_cnt #(.WIDTH(32)) u_perf_if (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_if),
    .count (perf_if_wait)
  );

  mem_arb_perf_cnt #(.WIDTH(32)) u_perf_dm (
    .clk   (clk),
    .rst   (rst),
    .en    (stall_mem),
    .count (perf_dm_wait)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a variable-latency memory model. Define MEM_PORT_ARB_PERF_EN to also test counters.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_adr = '0, dm_adr = '0, dm_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_adr, mem_wdata;
  logic        if_ready, dm_ready, mem_req, mem_we, stall_if, stall_mem;
`ifdef MEM_PORT_ARB_PERF_EN
  logic [31:0] perf_if_wait, perf_dm_wait;
`endif

  int total = 0;
  int bad = 0;

  // Memory model state; the responder only reads the configuration written by the tests.
  logic [31:0] store_mem [logic [31:0]];
  int          lat_cfg = 1;
  bit          resp_on = 1'b1;
  bit          force_ack = 1'b0;
  logic [31:0] force_data = '0;
  int          wait_cnt = 0;
  bit          acked = 1'b0;
  logic [31:0] first_adr, first_wdata, obs_adr, obs_wdata;
  logic        first_we, obs_we;
  bit          obs_stable = 1'b0;
  int          obs_req_cycles = 0;

  logic [31:0] exp_if_rdata = '0;
  logic [31:0] exp_dm_rdata = '0;

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_adr    (if_adr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_adr    (dm_adr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
`ifdef MEM_PORT_ARB_PERF_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_wait (perf_dm_wait)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (store_mem.exists(a)) return store_mem[a];
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory: acks lat_cfg cycles after mem_req first appears (mem_req high lat_cfg cycles).
  always @(posedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = force_data;
    end else if (resp_on && mem_req && !acked) begin
      wait_cnt++;
      if (wait_cnt == 1) begin
        first_adr   = mem_adr;
        first_we    = mem_we;
        first_wdata = mem_wdata;
        obs_stable  = 1'b1;
      end else if (mem_adr !== first_adr || mem_we !== first_we || mem_wdata !== first_wdata) begin
        obs_stable = 1'b0;
      end
      if (wait_cnt >= lat_cfg) begin
        mem_ack        = 1'b1;
        mem_rdata      = mem_we ? $urandom : mem_word(mem_adr);
        acked          = 1'b1;
        obs_adr        = first_adr;
        obs_we         = first_we;
        obs_wdata      = first_wdata;
        obs_req_cycles = wait_cnt;
      end
    end else if (!mem_req) begin
      wait_cnt = 0;
      acked    = 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%b exp=0", mem_we); end
    total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_if_ready got=%b exp=0", if_ready); end
    total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_dm_ready got=%b exp=0", dm_ready); end
    total++; if (mem_adr !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_adr got=%h exp=0", mem_adr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_if_rdata got=%h exp=0", if_rdata); end
    total++; if (dm_rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_dm_rdata got=%h exp=0", dm_rdata); end
    total++; if ({stall_if, stall_mem} !== 2'b00) begin bad++; $display("[TB] FAIL reset_stalls got=%b exp=00", {stall_if, stall_mem}); end
    rst = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask

  task automatic test_fetch();
    int c;
    @(negedge clk);
    lat_cfg = 3; if_adr = 32'h40; if_req = 1'b1;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      total++;
      if (stall_if !== (c < 4)) begin bad++; $display("[TB] FAIL fetch_stall_if cyc=%0d got=%b exp=%b", c, stall_if, c < 4); end
      if (if_ready) break;
    end
    total++; if (c !== 4) begin bad++; $display("[TB] FAIL fetch_latency got=%0d exp=4", c); end
    total++; if (obs_req_cycles !== 3) begin bad++; $display("[TB] FAIL fetch_req_cycles got=%0d exp=3", obs_req_cycles); end
    total++; if (obs_we !== 1'b0 || obs_adr !== 32'h40) begin bad++; $display("[TB] FAIL fetch_mem_cmd got=we%b/%h exp=we0/00000040", obs_we, obs_adr); end
    total++; if (if_rdata !== 32'h8C010004) begin bad++; $display("[TB] FAIL fetch_rdata got=%h exp=8c010004", if_rdata); end
    exp_if_rdata = 32'h8C010004;
    if_req = 1'b0;
    @(negedge clk);
    total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL fetch_ready_pulse got=%b exp=0", if_ready); end
  endtask

  task automatic test_simultaneous();
    int c;
    logic [31:0] d_exp, i_exp;
    d_exp = mem_word(32'h100);
    i_exp = mem_word(32'h44);
    lat_cfg = 2;
    if_adr = 32'h44; if_req = 1'b1; dm_adr = 32'h100; dm_read = 1'b1;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      total++; if (if_ready !== 1'b0) begin bad++; $display("[TB] FAIL simul_if_early got=%b exp=0", if_ready); end
      if (dm_ready) break;
    end
    total++; if (c !== 3) begin bad++; $display("[TB] FAIL simul_dm_latency got=%0d exp=3", c); end
    total++; if (obs_adr !== 32'h100) begin bad++; $display("[TB] FAIL simul_first_adr got=%h exp=00000100", obs_adr); end
    total++; if (dm_rdata !== d_exp) begin bad++; $display("[TB] FAIL simul_dm_rdata got=%h exp=%h", dm_rdata, d_exp); end
    exp_dm_rdata = d_exp;
    dm_read = 1'b0;
    // One IDLE cycle after the data response, then the fetch request becomes visible.
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (mem_req) break;
    end
    total++; if (c !== 2 || mem_adr !== 32'h44) begin bad++; $display("[TB] FAIL simul_fetch_issue got=cyc%0d/%h exp=cyc2/00000044", c, mem_adr); end
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (if_ready) break;
    end
    total++; if (c !== 2) begin bad++; $display("[TB] FAIL simul_if_latency got=%0d exp=2", c); end
    total++; if (if_rdata !== i_exp) begin bad++; $display("[TB] FAIL simul_if_rdata got=%h exp=%h", if_rdata, i_exp); end
    exp_if_rdata = i_exp;
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store();
    int c;
    lat_cfg = 2;
    dm_adr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_write = 1'b1;
    c = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (dm_ready) break;
    end
    total++; if (c !== 3) begin bad++; $display("[TB] FAIL store_latency got=%0d exp=3", c); end
    total++; if (obs_we !== 1'b1 || obs_wdata !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL store_mem_cmd got=we%b/%h exp=we1/deadbeef", obs_we, obs_wdata); end
    total++; if (dm_rdata !== exp_dm_rdata) begin bad++; $display("[TB] FAIL store_dm_rdata_kept got=%h exp=%h", dm_rdata, exp_dm_rdata); end
    store_mem[32'h200] = 32'hDEADBEEF;
    dm_write = 1'b0;
    @(negedge clk);
    total++; if (dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL store_ready_pulse got=%b exp=0", dm_ready); end
  endtask

  task automatic test_spurious_ack();
    force_data = 32'h1234; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0 ||
          if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
        bad++;
        $display("[TB] FAIL spurious_ack got=req%b ir%b dr%b %h %h exp=req0 ir0 dr0 %h %h",
                 mem_req, if_ready, dm_ready, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
      end
    end
  endtask

  task automatic test_random();
    int c, kind, lat;
    logic is_data, is_wr, rdy, other;
    logic [31:0] adr, wd, rd_exp;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      lat  = $urandom_range(1, 5);
      adr  = 32'h300 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      wd   = $urandom;
      is_data = (kind != 0);
      is_wr   = (kind >= 2);
      rd_exp  = mem_word(adr);
      lat_cfg = lat;
      if_adr  = is_data ? $urandom : adr;
      dm_adr  = is_data ? adr : $urandom;
      dm_wdata = wd;
      if_req   = !is_data;
      dm_read  = (kind == 1) || (kind == 3);
      dm_write = is_wr;
      c = 0;
      while (c < 20) begin
        @(negedge clk);
        c++;
        rdy   = is_data ? dm_ready : if_ready;
        other = is_data ? if_ready : dm_ready;
        total++;
        if (stall_if !== (c < lat + 1) || stall_mem !== (is_data && (c < lat + 1)) || other !== 1'b0) begin
          bad++;
          $display("[TB] FAIL rand_stall i=%0d cyc=%0d got=si%b sm%b other%b exp=si%b sm%b other0",
                   i, c, stall_if, stall_mem, other, c < lat + 1, is_data && (c < lat + 1));
        end
        if (rdy) break;
      end
      total++; if (c !== lat + 1) begin bad++; $display("[TB] FAIL rand_latency i=%0d got=%0d exp=%0d", i, c, lat + 1); end
      total++;
      if (obs_adr !== adr || obs_we !== is_wr || !obs_stable || obs_req_cycles !== lat ||
          (is_wr && obs_wdata !== wd)) begin
        bad++;
        $display("[TB] FAIL rand_mem_cmd i=%0d got=%h we%b st%b n%0d wd%h exp=%h we%b st1 n%0d wd%h",
                 i, obs_adr, obs_we, obs_stable, obs_req_cycles, obs_wdata, adr, is_wr, lat, wd);
      end
      if (is_wr) store_mem[adr] = wd;
      else if (is_data) exp_dm_rdata = rd_exp;
      else exp_if_rdata = rd_exp;
      total++;
      if (if_rdata !== exp_if_rdata || dm_rdata !== exp_dm_rdata) begin
        bad++;
        $display("[TB] FAIL rand_rdata i=%0d got=%h %h exp=%h %h", i, if_rdata, dm_rdata, exp_if_rdata, exp_dm_rdata);
      end
      if_req = 1'b0; dm_read = 1'b0; dm_write = 1'b0;
      @(negedge clk);
      total++; if (if_ready !== 1'b0 || dm_ready !== 1'b0) begin bad++; $display("[TB] FAIL rand_ready_pulse i=%0d got=%b%b exp=00", i, if_ready, dm_ready); end
    end
  endtask

`ifdef MEM_PORT_ARB_PERF_EN
  task automatic test_perf();
    int c;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_if_rdata = '0; exp_dm_rdata = '0;
    total++; if (perf_if_wait !== 32'd0 || perf_dm_wait !== 32'd0) begin bad++; $display("[TB] FAIL perf_reset got=%0d %0d exp=0 0", perf_if_wait, perf_dm_wait); end
    lat_cfg = 4; dm_adr = 32'h180; dm_read = 1'b1;
    c = 0;
    while (c < 20) begin @(negedge clk); c++; if (dm_ready) break; end
    dm_read = 1'b0;
    @(negedge clk);
    lat_cfg = 2; if_adr = 32'h48; if_req = 1'b1;
    c = 0;
    while (c < 20) begin @(negedge clk); c++; if (if_ready) break; end
    if_req = 1'b0;
    @(negedge clk);
    total++; if (perf_dm_wait !== 32'd5) begin bad++; $display("[TB] FAIL perf_dm_wait got=%0d exp=5", perf_dm_wait); end
    total++; if (perf_if_wait !== 32'd8) begin bad++; $display("[TB] FAIL perf_if_wait got=%0d exp=8", perf_if_wait); end
  endtask
`endif

  task automatic test_reset_mid();
    resp_on = 1'b1; lat_cfg = 10;
    dm_adr = 32'h300; dm_read = 1'b1;
    @(negedge clk);
    total++; if (mem_req !== 1'b1) begin bad++; $display("[TB] FAIL rmid_busy got=%b exp=1", mem_req); end
    resp_on = 1'b0; rst = 1'b1; dm_read = 1'b0;
    @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rmid_req_clear got=%b exp=0", mem_req); end
    rst = 1'b0;
    @(negedge clk);
    force_data = 32'hCAFE0001; force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || if_ready !== 1'b0 || dm_ready !== 1'b0 ||
          mem_adr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
        bad++;
        $display("[TB] FAIL rmid_late_ack got=req%b we%b ir%b dr%b %h %h %h %h exp=all zero",
                 mem_req, mem_we, if_ready, dm_ready, mem_adr, mem_wdata, if_rdata, dm_rdata);
      end
    end
  endtask

  initial begin
    store_mem[32'h40] = 32'h8C010004;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_store();
    test_spurious_ack();
    test_random();
`ifdef MEM_PORT_ARB_PERF_EN
    test_perf();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage MIPS pipeline.
- Sequences each transaction with an FSM and captures read data.
- Generates stall signals that freeze the pipeline registers upstream of the waiting stage.
- MEM-stage requests have strict priority, because they belong to the older instruction.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  IF stage requests instruction fetch
if_adr  in  ADDR_W  fetch address (pc)
if_rdata  out  DATA_W  fetched instruction (registered)
if_ready  out  1  one-cycle pulse: if_rdata valid, fetch done
dm_read  in  1  MEM stage load request
dm_write  in  1  MEM stage store request
dm_adr  in  ADDR_W  data address (ALU result)
dm_wdata  in  DATA_W  store data
dm_rdata  out  DATA_W  load data (registered)
dm_ready  out  1  one-cycle pulse: data transaction done
mem_req  out  1  level request to memory, held until mem_ack
mem_we  out  1  1 = write
mem_adr  out  ADDR_W  memory address (registered)
mem_wdata  out  DATA_W  memory write data (registered)
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  one-cycle completion pulse from memory
stall_if  out  1  freeze PC and IF/ID register
stall_mem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers

Behaviour:
- FSM states:
  - IDLE
  - D_BUSY, I_BUSY: waiting for mem_ack
  - D_RESP, I_RESP: ready pulse
- Reset values: state IDLE; mem_req, mem_we, if_ready, dm_ready = 0; mem_adr, mem_wdata, if_rdata, dm_rdata = 0.
- IDLE:
  - If dm_read|dm_write: latch dm_adr/dm_wdata/dm_write into mem_adr/mem_wdata/mem_we, set mem_req = 1, go to D_BUSY.
  - Else if if_req: latch if_adr, mem_we = 0, mem_req = 1, go to I_BUSY.
  - Else stay in IDLE.
  - Simultaneous requests: data wins; the fetch waits.
- X_BUSY: hold mem_req and all mem_* outputs stable until mem_ack.
- On mem_ack in X_BUSY:
  - Clear mem_req.
  - On a read, capture mem_rdata into if_rdata or dm_rdata.
  - Go to X_RESP.
  - Stores leave dm_rdata unchanged.
- X_RESP: assert the matching ready for exactly that one cycle. No new request is accepted. Next state is IDLE.
- Minimum transaction latency: request seen in IDLE at cycle 0, ack at cycle 1 at the earliest, ready at cycle 2; total cycles = 2 + memory wait.
- Back-to-back: IDLE is re-entered after every response, so a pending fetch is arbitrated one cycle after a data response.
- mem_ack outside X_BUSY is ignored: no state change, no data capture.
- dm_read & dm_write together is treated as a write.
- Requesters must hold request, address and data stable until their ready. The arbiter samples them only in IDLE.
- Stalls (combinational from inputs and registered ready):
  - stall_mem = (dm_read|dm_write) & ~dm_ready
  - stall_if = stall_mem | (if_req & ~if_ready)
- Reset mid-transaction: return to IDLE with mem_req = 0 on the next edge. A late mem_ack is ignored, and no ready pulse is produced.

Optional Feature:
- Macro: MEM_PORT_ARB_PERF_EN.
- Defined:
  - Adds 32-bit outputs perf_if_wait and perf_dm_wait.
  - Each counts cycles in which stall_if and stall_mem respectively are high.
  - Counters clear on rst and saturate at all-ones (no wrap).
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package mem_arb_pkg holds:
  - FSM state enum (3-bit encoding: IDLE=0, D_BUSY=1, D_RESP=2, I_BUSY=3, I_RESP=4)
  - ADDR_W/DATA_W defaults
- One natural sub-module: mem_arb_perf_cnt, a saturating stall counter instantiated twice under the macro.
- The FSM stays in the top module.

Test Plan:
- Fetch only: if_req=1, if_adr=0x40, memory acks 3 cycles after mem_req with 0x8C010004 -> mem_req high 3 cycles, mem_we=0, if_ready pulses once 1 cycle after ack with if_rdata=0x8C010004, stall_if high until that cycle.
- Simultaneous requests: if_req=1 at 0x44 and dm_read=1 at 0x100 in the same cycle -> first mem_adr=0x100, dm_ready pulses, then mem_adr=0x44 issued exactly one cycle after the dm_ready cycle.
- Store: dm_write=1, dm_adr=0x200, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, dm_ready pulses, dm_rdata keeps its previous value.
- Spurious ack: mem_ack pulsed in IDLE with mem_rdata=0x1234 -> state stays IDLE, no ready pulse, if_rdata/dm_rdata unchanged.
- Reset mid-transaction: rst in D_BUSY before ack, then an ack 2 cycles later -> mem_req=0 one edge after rst, no dm_ready, all outputs at reset values.
- With MEM_PORT_ARB_PERF_EN: 5-cycle data stall followed by a 3-cycle fetch stall -> perf_dm_wait=5; perf_if_wait counts 5+3=8, since stall_if includes stall_mem.
